// File: rtl/p_decoder_3to5_acc_if.sv
// Position-beat input stream and reconstructed-mask output stream of p_decoder_3to5_acc.
interface p_decoder_3to5_acc_if #(
  parameter int MASK_W = 5,
  parameter int POS_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [POS_W-1:0]  in_pos;
  logic              in_last;
  logic              in_empty;
  logic              out_valid;
  logic              out_ready;
  logic [MASK_W-1:0] out_mask;
  logic [POS_W:0]    out_cnt;
  logic              out_err;

  modport master (
    output in_valid, in_pos, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_mask, out_cnt, out_err
  );

  modport slave (
    input  in_valid, in_pos, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_mask, out_cnt, out_err
  );
endinterface

// File: rtl/p_decoder_3to5_acc.sv
// Rebuilds MSB-first bitmasks from a stream of position codes, one group at a time,
// reporting popcount and a sticky per-group protocol error flag.
module p_decoder_3to5_acc #(
  parameter int MASK_W = 5,
  parameter int POS_W  = 3
) (
  input logic               clk,
  input logic               reset,
  p_decoder_3to5_acc_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state, state_next;
  logic              ready, accept, close;
  logic [MASK_W-1:0] hit, acc, acc_next, mask_r;
  logic [POS_W:0]    cnt_next, cnt_r;
  logic [POS_W-1:0]  last_pos;
  logic              err, err_next, err_r, first;
  logic              range_err, dup_err, order_err, beat_err;

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // A closing beat during the drain cycle re-enters HOLD with the new group.
  always_comb begin
    state_next = state;
    ready      = (state == COLLECT) | bus.out_ready;
    accept     = bus.in_valid & ready;
    close      = accept & (bus.in_last | bus.in_empty);
    if (close)
      state_next = HOLD;
    else if (state == HOLD && bus.out_ready)
      state_next = COLLECT;
  end

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (!bus.in_empty && bus.in_pos == POS_W'(MASK_W - 1 - i))
        hit[i] = 1'b1;
    end
    range_err = ({1'b0, bus.in_pos} >= (POS_W+1)'(MASK_W));
    dup_err   = |(acc & hit);
    order_err = !first && (bus.in_pos <= last_pos);
    if (bus.in_empty) beat_err = !first;
    else              beat_err = range_err | dup_err | order_err;
    acc_next = acc | hit;
    err_next = err | beat_err;
    cnt_next = '0;
    for (int unsigned i = 0; i < MASK_W; i++)
      cnt_next = cnt_next + (POS_W+1)'(acc_next[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      err      <= 1'b0;
      first    <= 1'b1;
      last_pos <= '0;
      mask_r   <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else if (accept) begin
      if (close) begin
        mask_r <= acc_next;
        cnt_r  <= cnt_next;
        err_r  <= err_next;
        acc    <= '0;
        err    <= 1'b0;
        first  <= 1'b1;
      end else begin
        acc <= acc_next;
        err <= err_next;
        if (!bus.in_empty) begin
          first    <= 1'b0;
          last_pos <= bus.in_pos;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = ready;
    bus.out_valid = (state == HOLD);
    bus.out_mask  = mask_r;
    bus.out_cnt   = cnt_r;
    bus.out_err   = err_r;
  end

endmodule

// File: tb/tb_p_decoder_3to5_acc.sv
// Directed table-driven bench for p_decoder_3to5_acc plus a full-mask backpressure sequence.
module tb_p_decoder_3to5_acc;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  p_decoder_3to5_acc_if #(.MASK_W(5), .POS_W(3)) bus ();

  p_decoder_3to5_acc #(.MASK_W(5), .POS_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ck: 0 = no output check, 1 = out_valid only, 2 = all outputs
  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] pos;
    logic       last;
    logic       empty;
    logic       ordy;
    logic       ck_rdy;
    logic       rdy;
    int         ck;
    logic       ov;
    logic [4:0] mask;
    logic [3:0] cnt;
    logic       oe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic v, logic [2:0] pos, logic last, logic empty,
                              logic ordy, logic ck_rdy, logic rdy, int ck, logic ov,
                              logic [4:0] mask, logic [3:0] cnt, logic oe);
    vec_t r;
    r.rst = rst; r.v = v; r.pos = pos; r.last = last; r.empty = empty; r.ordy = ordy;
    r.ck_rdy = ck_rdy; r.rdy = rdy; r.ck = ck; r.ov = ov; r.mask = mask; r.cnt = cnt; r.oe = oe;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [2:0] pos,
                       input logic last, input logic empty, input logic ordy);
    reset         = rst;
    bus.in_valid  = v;
    bus.in_pos    = pos;
    bus.in_last   = last;
    bus.in_empty  = empty;
    bus.out_ready = ordy;
  endtask

  initial begin
    int waited;
    //                rst v  pos  last emp ordy ckr rdy ck ov  mask      cnt  oe
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 1, 0, 1, 2, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 1, 1, 1, 2, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 1, 0, 1, 1, 1, 2, 1, 5'b10101, 4'd3, 0));
    vecs.push_back(mk(0, 1, 3'd0, 0, 1, 1, 1, 1, 2, 1, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 1, 0, 1, 1, 1, 2, 1, 5'b01000, 4'd1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 1, 0, 1, 1, 1, 2, 1, 5'b01010, 4'd2, 1));
    vecs.push_back(mk(0, 1, 3'd4, 1, 0, 1, 1, 1, 2, 1, 5'b00001, 4'd1, 0));
    vecs.push_back(mk(0, 1, 3'd6, 1, 0, 1, 1, 1, 2, 1, 5'b00000, 4'd0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 1, 0, 0, 1, 1, 2, 1, 5'b00100, 4'd1, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1, 3'd0, 1, 0, 0, 1, 0, 2, 1, 5'b00100, 4'd1, 0));
    vecs.push_back(mk(0, 1, 3'd0, 1, 0, 1, 1, 1, 2, 1, 5'b10000, 4'd1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 1, 0, 1, 1, 1, 2, 1, 5'b00001, 4'd1, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 1, 0, 1, 2, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 1, 0, 1, 1, 1, 2, 1, 5'b01000, 4'd1, 0));
    vecs.push_back(mk(1, 1, 3'd3, 1, 0, 0, 0, 1, 2, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 1, 0, 1, 1, 1, 2, 1, 5'b00001, 4'd1, 0));
    vecs.push_back(mk(0, 1, 3'd2, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 1, 0, 1, 1, 1, 2, 1, 5'b00100, 4'd1, 1));
    vecs.push_back(mk(0, 1, 3'd1, 0, 0, 1, 1, 1, 1, 0, 5'b00000, 4'd0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 0, 1, 1, 1, 1, 2, 1, 5'b01000, 4'd1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].pos, vecs[i].last, vecs[i].empty, vecs[i].ordy);
      #1;
      if (vecs[i].ck_rdy) chk("in_ready", i, {7'd0, bus.in_ready}, {7'd0, vecs[i].rdy});
      @(posedge clk);
      #1;
      if (vecs[i].ck >= 1) chk("out_valid", i, {7'd0, bus.out_valid}, {7'd0, vecs[i].ov});
      if (vecs[i].ck >= 2) begin
        chk("out_mask", i, {3'd0, bus.out_mask}, {3'd0, vecs[i].mask});
        chk("out_cnt",  i, {4'd0, bus.out_cnt},  {4'd0, vecs[i].cnt});
        chk("out_err",  i, {7'd0, bus.out_err},  {7'd0, vecs[i].oe});
      end
    end

    // Full five-bit group, then backpressure: result must appear and hold steady.
    for (int p = 0; p < 5; p++) begin
      drive(0, 1, 3'(p), p == 4, 0, 1);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 3'd0, 0, 0, 0);
    waited = 0;
    while (!bus.out_valid && waited < 5) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("full_wait", 100, 8'(waited), 8'd0);
    for (int k = 0; k < 3; k++) begin
      chk("full_mask", 100 + k, {3'd0, bus.out_mask}, 8'h1f);
      chk("full_cnt",  100 + k, {4'd0, bus.out_cnt},  8'd5);
      chk("full_vld",  100 + k, {7'd0, bus.out_valid}, 8'd1);
      @(posedge clk);
      #1;
    end
    chk("full_err", 103, {7'd0, bus.out_err}, 8'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_vld", 104, {7'd0, bus.out_valid}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
